// File: rtl/spi_burst_sequencer_pkg.sv
// rtl/spi_burst_sequencer_pkg.sv - register map, SPI peripheral constants and FSM encoding
package spi_burst_sequencer_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_TXPUSH = 2'd1;
   localparam logic [1:0] REG_RXPOP  = 2'd2;
   localparam logic [1:0] REG_COUNT  = 2'd3;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_IE       = 1;
   localparam int CTRL_TXOVF    = 2;
   localparam int CTRL_RXUNF    = 3;
   localparam int CTRL_TXEMPTY  = 4;
   localparam int CTRL_RXNEMPTY = 5;
   localparam int CTRL_BUSY     = 6;

   localparam logic [1:0]  SPI_CTRL  = 2'd0;
   localparam logic [1:0]  SPI_TXD   = 2'd1;
   localparam logic [1:0]  SPI_RXD   = 2'd2;
   localparam logic [15:0] SPI_START = 16'h0080;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_POLL  = 3'd3,
      ST_FETCH = 3'd4
   } state_t;

endpackage

// File: rtl/spi_burst_sequencer_fifo.sv
// rtl/spi_burst_sequencer_fifo.sv - synchronous byte FIFO used for the TX and RX queues
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_byte_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          iClk,
   input  logic          iRst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [7:0]    i_din,
   output logic [7:0]    o_dout,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wr;
   logic [AW:0] r_rd;
   logic        w_push;
   logic        w_pop;

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + (AW+1)'(1);
         if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
      end
   end

   always_ff @(posedge iClk) begin
      if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
   end

   assign o_count = r_wr - r_rd;
   assign o_empty = (r_wr == r_rd);
   assign o_full  = (o_count == DEPTH[AW:0]);
   assign o_dout  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/spi_burst_sequencer.sv
// rtl/spi_burst_sequencer.sv - runs queued byte transfers on the SPI peripheral register port
// The CPU fills TX and drains RX; the FSM does load/start/poll/fetch per byte.
module spi_burst_sequencer #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic [1:0]  iAddr,
   input  logic [15:0] iData,
   output logic [15:0] oData,
   input  logic        iWrite,
   input  logic        iEnable,
   output logic        oInt,
   output logic [1:0]  oSpiAddr,
   output logic [15:0] oSpiData,
   input  logic [15:0] iSpiData,
   output logic        oSpiWrite,
   output logic        oSpiEnable
);
   import spi_burst_sequencer_pkg::*;

   state_t      r_state;
   state_t      w_next;
   logic        r_en;
   logic        r_ie;
   logic        r_txovf;
   logic        r_rxunf;
   logic        r_int;
   logic        w_cpu_wr;
   logic        w_cpu_rd;
   logic        w_tx_push;
   logic        w_tx_pop;
   logic        w_rx_push;
   logic        w_rx_pop;
   logic [7:0]  w_tx_dout;
   logic [7:0]  w_rx_dout;
   logic        w_tx_full;
   logic        w_tx_empty;
   logic        w_rx_full;
   logic        w_rx_empty;
   logic [AW:0] w_tx_count;
   logic [AW:0] w_rx_count;
   logic        w_busy;
   logic [15:0] w_ctrl;
   logic [15:0] w_rdata;
   logic        w_unused;

   assign w_cpu_wr  = iEnable & iWrite;
   assign w_cpu_rd  = iEnable & ~iWrite;
   assign w_tx_push = w_cpu_wr & (iAddr == REG_TXPUSH);
   assign w_tx_pop  = (r_state == ST_LOAD);
   assign w_rx_push = (r_state == ST_FETCH);
   assign w_rx_pop  = w_cpu_rd & (iAddr == REG_RXPOP);
   assign w_busy    = (r_state != ST_IDLE);
   assign w_unused  = &{1'b0, iData[15:8], iSpiData[15:8]};

   sync_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
      .iClk    (iClk),
      .iRst    (iRst),
      .i_push  (w_tx_push),
      .i_pop   (w_tx_pop),
      .i_din   (iData[7:0]),
      .o_dout  (w_tx_dout),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (w_tx_count)
   );

   // RX data comes straight off the peripheral read port during FETCH.
   sync_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
      .iClk    (iClk),
      .iRst    (iRst),
      .i_push  (w_rx_push),
      .i_pop   (w_rx_pop),
      .i_din   (iSpiData[7:0]),
      .o_dout  (w_rx_dout),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_count (w_rx_count)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_en    <= 1'b0;
         r_ie    <= 1'b0;
         r_txovf <= 1'b0;
         r_rxunf <= 1'b0;
         r_int   <= 1'b0;
      end else begin
         if (w_cpu_wr && iAddr == REG_CTRL) begin
            r_en <= iData[CTRL_EN];
            r_ie <= iData[CTRL_IE];
            if (iData[CTRL_TXOVF]) r_txovf <= 1'b0;
            if (iData[CTRL_RXUNF]) r_rxunf <= 1'b0;
         end
         if (w_tx_push && w_tx_full)  r_txovf <= 1'b1;
         if (w_rx_pop && w_rx_empty)  r_rxunf <= 1'b1;
         r_int <= r_ie & (~w_rx_empty | r_txovf | r_rxunf | (w_tx_empty & ~w_busy & r_en));
      end
   end

   always_comb begin
      w_ctrl                = '0;
      w_ctrl[CTRL_EN]       = r_en;
      w_ctrl[CTRL_IE]       = r_ie;
      w_ctrl[CTRL_TXOVF]    = r_txovf;
      w_ctrl[CTRL_RXUNF]    = r_rxunf;
      w_ctrl[CTRL_TXEMPTY]  = w_tx_empty;
      w_ctrl[CTRL_RXNEMPTY] = ~w_rx_empty;
      w_ctrl[CTRL_BUSY]     = w_busy;
   end

   always_comb begin
      w_rdata = '0;
      case (iAddr)
         REG_CTRL:  w_rdata = w_ctrl;
         REG_RXPOP: w_rdata = w_rx_empty ? 16'h0000 : {8'h00, w_rx_dout};
         REG_COUNT: w_rdata = {8'(w_tx_count), 8'(w_rx_count)};
         default:   w_rdata = '0;
      endcase
   end

   assign oData = iEnable ? w_rdata : 16'bz;
   assign oInt  = r_int;

   always_ff @(posedge iClk) begin
      if (iRst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   // A transfer is only started with RX space, so FETCH can never overflow RX.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (r_en && !w_tx_empty && !w_rx_full) w_next = ST_LOAD;
         ST_LOAD:  w_next = ST_START;
         ST_START: w_next = ST_POLL;
         ST_POLL:  if (!iSpiData[7]) w_next = ST_FETCH;
         ST_FETCH: w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      oSpiAddr   = '0;
      oSpiData   = '0;
      oSpiWrite  = 1'b0;
      oSpiEnable = 1'b0;
      case (r_state)
         ST_LOAD: begin
            oSpiAddr   = SPI_TXD;
            oSpiData   = {8'h00, w_tx_dout};
            oSpiWrite  = 1'b1;
            oSpiEnable = 1'b1;
         end
         ST_START: begin
            oSpiAddr   = SPI_CTRL;
            oSpiData   = SPI_START;
            oSpiWrite  = 1'b1;
            oSpiEnable = 1'b1;
         end
         ST_POLL: begin
            oSpiAddr   = SPI_CTRL;
            oSpiEnable = 1'b1;
         end
         ST_FETCH: begin
            oSpiAddr   = SPI_RXD;
            oSpiEnable = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// tb/tb_spi_burst_sequencer.sv - self-checking bench for spi_burst_sequencer
`timescale 1ns/1ps
module tb_spi_burst_sequencer;

   localparam int         DEPTH  = 8;
   localparam logic [1:0] A_CTRL = 2'd0;
   localparam logic [1:0] A_PUSH = 2'd1;
   localparam logic [1:0] A_POP  = 2'd2;
   localparam logic [1:0] A_CNT  = 2'd3;

   logic        iClk = 1'b0;
   logic        iRst = 1'b1;
   logic [1:0]  iAddr = '0;
   logic [15:0] iData = '0;
   logic        iWrite = 1'b0;
   logic        iEnable = 1'b0;
   wire  [15:0] oData;
   wire         oInt;
   wire  [1:0]  oSpiAddr;
   wire  [15:0] oSpiData;
   wire         oSpiWrite;
   wire         oSpiEnable;
   wire  [15:0] iSpiData;

   spi_burst_sequencer #(.DEPTH(DEPTH), .AW(3)) dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iAddr      (iAddr),
      .iData      (iData),
      .oData      (oData),
      .iWrite     (iWrite),
      .iEnable    (iEnable),
      .oInt       (oInt),
      .oSpiAddr   (oSpiAddr),
      .oSpiData   (oSpiData),
      .iSpiData   (iSpiData),
      .oSpiWrite  (oSpiWrite),
      .oSpiEnable (oSpiEnable)
   );

   always #5 iClk = ~iClk;

   int n_checks = 0;
   int n_errors = 0;

   // SPI peripheral model: busy for a programmable time after start, RX = TX ^ 0xFF
   logic [7:0] spi_txd = '0;
   logic [7:0] spi_rxd = '0;
   int         spi_cnt = 0;
   int         busy_min = 20;
   int         busy_max = 20;

   always @(posedge iClk) begin
      if (oSpiEnable && oSpiWrite && oSpiAddr == 2'd1) spi_txd <= oSpiData[7:0];
      if (oSpiEnable && oSpiWrite && oSpiAddr == 2'd0 && oSpiData[7]) begin
         spi_cnt <= int'($urandom_range(busy_max, busy_min));
         spi_rxd <= spi_txd ^ 8'hFF;
      end else if (spi_cnt > 0) begin
         spi_cnt <= spi_cnt - 1;
      end
   end

   assign iSpiData = (oSpiAddr == 2'd0) ? {8'h00, (spi_cnt != 0), 7'h00} :
                     (oSpiAddr == 2'd2) ? {8'h00, spi_rxd} : 16'h0000;

   typedef struct packed {
      logic        wr;
      logic [1:0]  addr;
      logic [15:0] data;
   } bus_t;

   bus_t       bus_q[$];
   logic [7:0] exp_spi_q[$];
   logic [7:0] exp_rx_q[$];

   always @(negedge iClk) begin
      if (oSpiEnable) bus_q.push_back({oSpiWrite, oSpiAddr, oSpiData});
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
      iEnable = 1'b1; iWrite = 1'b1; iAddr = a; iData = d;
      @(posedge iClk); #1;
      iEnable = 1'b0; iWrite = 1'b0; iAddr = '0; iData = '0;
   endtask

   task automatic cpu_read(input logic [1:0] a, output logic [15:0] d);
      iEnable = 1'b1; iWrite = 1'b0; iAddr = a;
      @(negedge iClk);
      d = oData;
      @(posedge iClk); #1;
      iEnable = 1'b0; iAddr = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge iClk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      cpu_write(A_PUSH, {8'hC3, b});
      exp_spi_q.push_back(b);
      exp_rx_q.push_back(b ^ 8'hFF);
   endtask

   task automatic wait_count(input logic [15:0] exp, input int budget, input string name);
      logic [15:0] v;
      int k = 0;
      do begin
         cpu_read(A_CNT, v);
         k++;
      end while (v !== exp && k < budget);
      check(name, v, exp);
   endtask

   task automatic pop_expect(input string name);
      logic [15:0] v;
      logic [7:0]  e;
      cpu_read(A_POP, v);
      e = (exp_rx_q.size() > 0) ? exp_rx_q.pop_front() : 8'h00;
      check(name, v, {8'h00, e});
   endtask

   function automatic bus_t bus_at(input int idx);
      if (idx < bus_q.size()) return bus_q[idx];
      return '{wr: 1'b1, addr: 2'd3, data: 16'hFFFF};
   endfunction

   // Splits the logged SPI accesses into transfers and checks each against the pushed bytes.
   task automatic analyze_bus(input int min_polls, input int exp_xfers, input string tag);
      int   i = 0;
      int   xfers = 0;
      int   polls;
      bus_t e;
      logic [7:0] b;
      while (i < bus_q.size()) begin
         b = (exp_spi_q.size() > 0) ? exp_spi_q.pop_front() : 8'h00;
         e = bus_at(i); i++;
         check({tag, " load"}, {e.wr, e.addr, e.data}, {1'b1, 2'd1, 8'h00, b});
         e = bus_at(i); i++;
         check({tag, " start"}, {e.wr, e.addr, e.data}, {1'b1, 2'd0, 16'h0080});
         polls = 0;
         while (i < bus_q.size() && !bus_q[i].wr && bus_q[i].addr == 2'd0) begin
            polls++; i++;
         end
         check({tag, " poll count"}, (polls >= min_polls), 1);
         e = bus_at(i); i++;
         check({tag, " fetch"}, {e.wr, e.addr}, {1'b0, 2'd2});
         xfers++;
      end
      bus_q.delete();
      check({tag, " transfers"}, xfers, exp_xfers);
   endtask

   typedef struct {
      logic [1:0]  addr;
      logic        wr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;

   vec_t        vecs[13];
   logic [15:0] v;
   int          n_rand;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{A_CTRL, 1'b0, 16'h0000, 16'h0010};
      vecs[1]  = '{A_CNT,  1'b0, 16'h0000, 16'h0000};
      vecs[2]  = '{A_PUSH, 1'b0, 16'h0000, 16'h0000};
      vecs[3]  = '{A_POP,  1'b0, 16'h0000, 16'h0000};
      vecs[4]  = '{A_CTRL, 1'b0, 16'h0000, 16'h0018};
      vecs[5]  = '{A_CTRL, 1'b1, 16'hFFF8, 16'h0000};
      vecs[6]  = '{A_CTRL, 1'b0, 16'h0000, 16'h0010};
      vecs[7]  = '{A_CTRL, 1'b1, 16'h0002, 16'h0000};
      vecs[8]  = '{A_CTRL, 1'b0, 16'h0000, 16'h0012};
      vecs[9]  = '{A_PUSH, 1'b1, 16'hFF3C, 16'h0000};
      vecs[10] = '{A_CNT,  1'b0, 16'h0000, 16'h0100};
      vecs[11] = '{A_CTRL, 1'b0, 16'h0000, 16'h0002};
      vecs[12] = '{A_CTRL, 1'b1, 16'h0000, 16'h0000};

      repeat (3) @(posedge iClk);
      #1 iRst = 1'b0;
      check("reset oInt", oInt, 0);
      check("reset spi outputs", {oSpiAddr, oSpiData, oSpiWrite, oSpiEnable}, 0);

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].wr) begin
            cpu_write(vecs[i].addr, vecs[i].wdata);
            if (vecs[i].addr == A_PUSH) begin
               exp_spi_q.push_back(vecs[i].wdata[7:0]);
               exp_rx_q.push_back(vecs[i].wdata[7:0] ^ 8'hFF);
            end
         end else begin
            cpu_read(vecs[i].addr, v);
            check($sformatf("vec%0d", i), v, vecs[i].exp);
         end
      end
      check("no spi while disabled", bus_q.size(), 0);

      // single byte 0xA5 behind the 0x3C left by the table, 20-cycle busy
      push_byte(8'hA5);
      cpu_write(A_CTRL, 16'h0001);
      wait_count(16'h0002, 300, "a5 count");
      analyze_bus(20, 2, "a5");
      cpu_read(A_POP, v); check("pop 3c", v, 16'h00C3);
      cpu_read(A_POP, v); check("pop a5", v, 16'h005A);
      exp_rx_q.delete();

      // interrupt sources
      cpu_write(A_CTRL, 16'h0003);
      idle(1);
      check("int tx empty idle", oInt, 1);
      cpu_write(A_CTRL, 16'h0002);
      idle(1);
      check("int en off", oInt, 0);
      cpu_read(A_POP, v);
      check("underflow data", v, 16'h0000);
      check("int latency", oInt, 0);
      idle(1);
      check("int rxunf", oInt, 1);
      cpu_read(A_CTRL, v); check("ctrl rxunf", v, 16'h001A);
      cpu_write(A_CTRL, 16'h000A);
      idle(2);
      check("int cleared", oInt, 0);
      cpu_read(A_CTRL, v); check("ctrl rxunf cleared", v, 16'h0012);
      cpu_write(A_CTRL, 16'h0000);

      // fill TX with EN=0, overflow, then burst
      for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h11 * (i + 1)));
      cpu_write(A_PUSH, 16'h0077);
      cpu_read(A_CNT, v);  check("full count", v, 16'h0800);
      cpu_read(A_CTRL, v); check("txovf", v, 16'h0004);
      cpu_write(A_CTRL, 16'h0001);
      wait_count(16'h0008, 600, "burst count");
      analyze_bus(20, 8, "burst");
      for (int i = 0; i < DEPTH; i++) pop_expect($sformatf("burst pop%0d", i));
      cpu_read(A_CNT, v);  check("drained count", v, 16'h0000);
      cpu_read(A_CTRL, v); check("drained ctrl", v, 16'h0015);
      cpu_write(A_CTRL, 16'h0005);

      // RX full blocks new transfers
      busy_min = 2; busy_max = 4;
      for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h40 + i));
      wait_count(16'h0008, 300, "rxfull count");
      analyze_bus(1, 8, "rxfill");
      push_byte(8'h9A);
      push_byte(8'h9B);
      idle(40);
      check("rxfull no spi", bus_q.size(), 0);
      cpu_read(A_CNT, v); check("rxfull hold count", v, 16'h0208);
      pop_expect("rxfull pop");
      wait_count(16'h0108, 100, "one more count");
      idle(20);
      analyze_bus(1, 1, "one more");

      // reset while polling
      busy_min = 20; busy_max = 20;
      pop_expect("pre-reset pop");
      idle(5);
      cpu_read(A_CTRL, v); check("busy before reset", v[6], 1);
      iRst = 1'b1;
      @(posedge iClk); #1;
      iRst = 1'b0;
      check("reset spi enable", oSpiEnable, 0);
      check("reset oInt mid", oInt, 0);
      cpu_read(A_CTRL, v); check("reset ctrl", v, 16'h0010);
      cpu_read(A_CNT, v);  check("reset count", v, 16'h0000);
      exp_spi_q.delete();
      exp_rx_q.delete();
      idle(30);
      bus_q.delete();

      // random traffic against the queue model
      busy_min = 0; busy_max = 5;
      n_rand = 0;
      cpu_write(A_CTRL, 16'h0001);
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
               if (exp_rx_q.size() < DEPTH) begin
                  push_byte(8'($urandom_range(0, 254)));
                  n_rand++;
               end else idle(1);
            end
            4, 5, 6: begin
               cpu_read(A_POP, v);
               if (v != 16'h0000) begin
                  if (exp_rx_q.size() == 0) check("rand pop unexpected", v, 16'h0000);
                  else check("rand pop", v, {8'h00, exp_rx_q.pop_front()});
               end
            end
            7: begin
               cpu_read(A_CNT, v);
               check("rand count bound", (int'(v[15:8]) + int'(v[7:0]) <= exp_rx_q.size()), 1);
            end
            8: idle(1);
            default: cpu_write(A_CTRL, {12'h000, 2'b11, 1'b0, ($urandom_range(0, 3) != 0)});
         endcase
      end
      cpu_write(A_CTRL, 16'h0001);
      for (int k = 0; k < 2000 && exp_rx_q.size() > 0; k++) begin
         cpu_read(A_POP, v);
         if (v != 16'h0000) check("drain pop", v, {8'h00, exp_rx_q.pop_front()});
      end
      check("rand drained", exp_rx_q.size(), 0);
      idle(5);
      analyze_bus(1, n_rand, "rand");
      check("rand spi queue empty", exp_spi_q.size(), 0);
      cpu_read(A_CNT, v); check("rand final count", v, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
